iobus_uart_tx: RTL

IOBUS_UART_TX -- requirements
Module: iobus_uart_tx

---
 rtl/iobus_uart_tx_pkg.sv | 37 +++
 rtl/iobus_uart_tx_if.sv | 13 +
 rtl/iobus_uart_tx_fifo.sv | 51 +++++
 rtl/iobus_uart_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/iobus_uart_tx_pkg.sv
// Shared IOBUS constants for the UART transmitter: default address map,
// status register bit positions and the transmit state encoding.
package iobus_pkg;

  localparam logic [31:0] UART_TX_BASE  = 32'h1100_0040;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  // Unused status bits stay zero so several responders can be OR-combined.
  function automatic logic [31:0] packStatus(input logic full,
                                             input logic empty,
                                             input logic busy,
                                             input logic overrun,
                                             input logic [3:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_FULL]              = full;
    s[STAT_EMPTY]             = empty;
    s[STAT_BUSY]              = busy;
    s[STAT_OVERRUN]           = overrun;
    s[STAT_COUNT_LSB +: 4]    = count;
    return s;
  endfunction

endpackage

// File: rtl/iobus_uart_tx_if.sv
// CPU-side IOBUS connection: address, write data, write strobe and the
// combinational read data returned by the responder.
interface iobus_uart_tx_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input  IOBUS_IN);
  modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR, output IOBUS_IN);

endinterface

// File: rtl/iobus_uart_tx_fifo.sv
// Synchronous FIFO with exact occupancy count; DEPTH must be a power of two
// (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is only legal when a pop frees the slot this edge.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + CNT_W'(1);
      else if (doPop && !doPush) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: data register pushes bytes into a FIFO,
// status register reports FIFO/FSM state and a sticky overrun flag.
module iobus_uart_tx
  import iobus_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = UART_TX_BASE
) (
  input  logic          CLK,
  input  logic          RST,
  iobus_uart_tx_if.slave bus,
  output logic          TX
);

  localparam int              CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int              BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;

  uartState_t        state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0]        bitIdx, bitNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              txReg, txNext;
  logic              overrun;

  logic              wrDataHit;
  logic              wrStatusHit;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [7:0]        fifoHead;
  logic [CNT_W-1:0]  fifoCount;
  logic              overrunSet;
  logic              overrunClear;
  logic              unusedOutBits;

  assign wrDataHit    = bus.IOBUS_WR && (bus.IOBUS_ADDR == BASE_ADDR);
  assign wrStatusHit  = bus.IOBUS_WR && (bus.IOBUS_ADDR == STATUS_ADDR);
  assign overrunSet   = wrDataHit && fifoFull && !fifoPop;
  assign overrunClear = wrStatusHit && bus.IOBUS_OUT[STAT_OVERRUN];
  assign unusedOutBits = ^bus.IOBUS_OUT[31:8];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) txFifo (
    .clk    (CLK),
    .rst    (RST),
    .push   (wrDataHit),
    .pop    (fifoPop),
    .wrData (bus.IOBUS_OUT[7:0]),
    .rdData (fifoHead),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // A fresh overrun on the same edge as a clear wins, so no drop goes unreported.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               overrun <= 1'b0;
    else if (overrunSet)   overrun <= 1'b1;
    else if (overrunClear) overrun <= 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // TX is registered, so each branch computes the line level for the next bit.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = txReg;
    fifoPop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = fifoHead;
          baudNext  = '0;
          txNext    = 1'b0;
          stateNext = START;
        end
      end
      START: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext  = '0;
          bitNext   = '0;
          txNext    = shiftReg[0];
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            txNext    = 1'b1;
            stateNext = STOP;
          end else begin
            bitNext = bitIdx + 3'd1;
            txNext  = shiftReg[bitIdx + 3'd1];
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            shiftNext = fifoHead;
            txNext    = 1'b0;
            stateNext = START;
          end else begin
            txNext    = 1'b1;
            stateNext = IDLE;
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      default: begin
        txNext    = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  assign TX = txReg;

  assign bus.IOBUS_IN = (bus.IOBUS_ADDR == STATUS_ADDR)
                      ? packStatus(fifoFull, fifoEmpty, (state != IDLE), overrun, 4'(fifoCount))
                      : 32'h0;

endmodule
